// File: rtl/regfile_pkg.sv
// Shared types and slicing helpers for the multi-port register file.
package regfile_pkg;

  // Sweep FSM: CLEAR zeroes the array after reset, RUN is normal operation.
  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_e;

  // Low bit of field idx in a flat bus made of fields w bits wide.
  function automatic int slice_lo(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits used by decode for hazard detection.
// A reserve marks a register as waiting on a producer; a write retires it.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic                  wr0,
  input  logic [ADDR_W-1:0]     wa0,
  input  logic                  wr1,
  input  logic [ADDR_W-1:0]     wa1,
  input  logic                  res_valid,
  input  logic [ADDR_W-1:0]     res_addr,
  input  logic [NRD*ADDR_W-1:0] ra,
  output logic [NRD-1:0]        pend
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0]  sb;
  logic [DEPTH-1:0]  sb_nx;
  logic              set_en;
  logic [ADDR_W-1:0] look_addr;
  logic              look_wr;
  logic              look_res;

  // A reserve only counts in RUN, and never for the hardwired zero register.
  assign set_en = run && res_valid && !((ZERO_REG != 0) && (res_addr == '0));

  // Next pending bits: a reserve beats a same-edge write because it belongs
  // to a newer producer than the one now writing back.
  always_comb begin
    sb_nx = sb;
    for (int j = 0; j < DEPTH; j++) begin
      if (set_en && (res_addr == ADDR_W'(j))) begin
        sb_nx[j] = 1'b1;
      end else if ((wr0 && (wa0 == ADDR_W'(j))) || (wr1 && (wa1 == ADDR_W'(j)))) begin
        sb_nx[j] = 1'b0;
      end
    end
  end

  // Pending bit register; reset clears every reservation.
  always_ff @(posedge clk) begin
    if (rst) begin
      sb <= '0;
    end else begin
      sb <= sb_nx;
    end
  end

  // Per read port lookup, masking a bit that the current write is retiring
  // unless a fresh reserve for the same register lands on the same edge.
  always_comb begin
    pend      = '0;
    look_addr = '0;
    look_wr   = 1'b0;
    look_res  = 1'b0;
    for (int i = 0; i < NRD; i++) begin
      look_addr = ra[slice_lo(i, ADDR_W) +: ADDR_W];
      look_wr   = (wr0 && (wa0 == look_addr)) || (wr1 && (wa1 == look_addr));
      look_res  = set_en && (res_addr == look_addr);
      pend[i]   = sb[look_addr] && !(look_wr && !look_res);
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file: NRD combinational read ports with
// write forwarding, two write ports (port 1 wins collisions), optional
// hardwired zero register, a post-reset clearing sweep and a pending
// scoreboard.
//
// Handshake: there is no valid/ready flow control. Each write or reserve
// enable is a single-cycle command taken on the next rising edge when busy
// is low; while busy is high every command is dropped, not stalled.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRD*ADDR_W-1:0] ra,
  output logic [NRD*DATA_W-1:0] rd,
  output logic [NRD-1:0]        pend,
  input  logic                  we0,
  input  logic [ADDR_W-1:0]     wa0,
  input  logic [DATA_W-1:0]     wd0,
  input  logic                  we1,
  input  logic [ADDR_W-1:0]     wa1,
  input  logic [DATA_W-1:0]     wd1,
  input  logic                  res_valid,
  input  logic [ADDR_W-1:0]     res_addr,
  output logic                  busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  rf_state_e         state;
  rf_state_e         state_nx;
  logic [ADDR_W-1:0] ctr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              run;
  logic              wr0;
  logic              wr1;
  logic [ADDR_W-1:0] rd_addr;

  assign run  = (state == RUN);
  assign busy = (state == CLEAR);

  // Effective writes: RUN only, and register 0 stays zero when hardwired.
  assign wr0 = run && we0 && !((ZERO_REG != 0) && (wa0 == '0));
  assign wr1 = run && we1 && !((ZERO_REG != 0) && (wa1 == '0));

  // Sweep FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
    end else begin
      state <= state_nx;
    end
  end

  // Sweep FSM next state: leave CLEAR once the last register is zeroed.
  always_comb begin
    state_nx = state;
    case (state)
      CLEAR:   if (ctr == LAST) state_nx = RUN;
      RUN:     state_nx = RUN;
      default: state_nx = CLEAR;
    endcase
  end

  // Sweep address counter; restarts from 0 on every reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctr <= '0;
    end else if (state == CLEAR) begin
      ctr <= ctr + 1'b1;
    end
  end

  // Storage: sweep zeroing in CLEAR, otherwise both write ports, with port 1
  // issued last so it wins when both target the same register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        mem[ctr] <= '0;
      end else begin
        if (wr0) mem[wa0] <= wd0;
        if (wr1) mem[wa1] <= wd1;
      end
    end
  end

  // Read muxes: busy, zero register, then forwarding from port 1, port 0,
  // and finally the stored value.
  always_comb begin
    rd      = '0;
    rd_addr = '0;
    for (int i = 0; i < NRD; i++) begin
      rd_addr = ra[slice_lo(i, ADDR_W) +: ADDR_W];
      if (busy) begin
        rd[slice_lo(i, DATA_W) +: DATA_W] = '0;
      end else if ((ZERO_REG != 0) && (rd_addr == '0)) begin
        rd[slice_lo(i, DATA_W) +: DATA_W] = '0;
      end else if (we1 && (wa1 == rd_addr)) begin
        rd[slice_lo(i, DATA_W) +: DATA_W] = wd1;
      end else if (we0 && (wa0 == rd_addr)) begin
        rd[slice_lo(i, DATA_W) +: DATA_W] = wd0;
      end else begin
        rd[slice_lo(i, DATA_W) +: DATA_W] = mem[rd_addr];
      end
    end
  end

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NRD      (NRD),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .wr0       (wr0),
    .wa0       (wa0),
    .wr1       (wr1),
    .wa1       (wa1),
    .res_valid (res_valid),
    .res_addr  (res_addr),
    .ra        (ra),
    .pend      (pend)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp with default parameters (32x32, 2 read ports,
// hardwired r0): reset sweep, mid-sweep reset, then a vector table covering
// forwarding, write collision, zero register and scoreboard behaviour.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  ra;
  logic [63:0] rd;
  logic [1:0]  pend;
  logic        we0, we1, res_valid;
  logic [4:0]  wa0, wa1, res_addr;
  logic [31:0] wd0, wd1;
  logic        busy;

  int n_vec  = 0;
  int n_miss = 0;
  int n_edge;

  typedef struct {
    logic        we0;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic        we1;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        res_valid;
    logic [4:0]  res_addr;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] exp_rd0;
    logic [31:0] exp_rd1;
    logic [1:0]  exp_pend;
  } vec_t;

  vec_t vecs[16];

  regfile_mp dut (
    .clk       (clk),
    .rst       (rst),
    .ra        (ra),
    .rd        (rd),
    .pend      (pend),
    .we0       (we0),
    .wa0       (wa0),
    .wd0       (wd0),
    .we1       (we1),
    .wa1       (wa1),
    .wd1       (wd1),
    .res_valid (res_valid),
    .res_addr  (res_addr),
    .busy      (busy)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard-style compare: one line per miscompare.
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    we0 = 1'b0; wa0 = '0; wd0 = '0;
    we1 = 1'b0; wa1 = '0; wd1 = '0;
    res_valid = 1'b0; res_addr = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle reset pulse; returns 1 ns after the edge with rst low.
  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Counts rising edges until busy drops, bounded so a stuck sweep still ends.
  task automatic count_sweep(output int n);
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
  endtask

  function automatic vec_t mk(input logic w0, input logic [4:0] a0, input logic [31:0] d0,
                              input logic w1, input logic [4:0] a1, input logic [31:0] d1,
                              input logic rv, input logic [4:0] raddr,
                              input logic [4:0] r0, input logic [4:0] r1,
                              input logic [31:0] e0, input logic [31:0] e1,
                              input logic [1:0] ep);
    vec_t v;
    v.we0 = w0; v.wa0 = a0; v.wd0 = d0;
    v.we1 = w1; v.wa1 = a1; v.wd1 = d1;
    v.res_valid = rv; v.res_addr = raddr;
    v.ra0 = r0; v.ra1 = r1;
    v.exp_rd0 = e0; v.exp_rd1 = e1; v.exp_pend = ep;
    return v;
  endfunction

  initial begin
    // Vector table; each row is checked combinationally, then clocked in.
    //           we0 wa0 wd0            we1 wa1 wd1            res rsa ra0 ra1 rd0            rd1            pend
    vecs[0]  = mk(1, 5,  32'hDEADBEEF, 0, 0,  32'h0,        0, 0,  5,  6,  32'hDEADBEEF, 32'h0,        2'b00); // fwd port 0
    vecs[1]  = mk(0, 0,  32'h0,        0, 0,  32'h0,        0, 0,  5,  0,  32'hDEADBEEF, 32'h0,        2'b00); // stored r5
    vecs[2]  = mk(1, 9,  32'h11,       1, 9,  32'h22,       0, 0,  9,  5,  32'h22,       32'hDEADBEEF, 2'b00); // collision
    vecs[3]  = mk(0, 0,  32'h0,        0, 0,  32'h0,        0, 0,  9,  9,  32'h22,       32'h22,       2'b00);
    vecs[4]  = mk(1, 0,  32'hFFFFFFFF, 0, 0,  32'h0,        1, 0,  0,  0,  32'h0,        32'h0,        2'b00); // r0 write+reserve
    vecs[5]  = mk(0, 0,  32'h0,        1, 0,  32'hFFFFFFFF, 0, 0,  0,  0,  32'h0,        32'h0,        2'b00);
    vecs[6]  = mk(0, 0,  32'h0,        0, 0,  32'h0,        1, 7,  7,  5,  32'h0,        32'hDEADBEEF, 2'b00); // reserve r7
    vecs[7]  = mk(0, 0,  32'h0,        0, 0,  32'h0,        0, 0,  7,  7,  32'h0,        32'h0,        2'b11);
    vecs[8]  = mk(0, 0,  32'h0,        1, 7,  32'h77,       1, 7,  7,  7,  32'h77,       32'h77,       2'b11); // write+reserve
    vecs[9]  = mk(0, 0,  32'h0,        0, 0,  32'h0,        0, 0,  7,  9,  32'h77,       32'h22,       2'b01);
    vecs[10] = mk(1, 7,  32'h70,       0, 0,  32'h0,        0, 0,  7,  9,  32'h70,       32'h22,       2'b00); // write retires
    vecs[11] = mk(0, 0,  32'h0,        0, 0,  32'h0,        0, 0,  7,  7,  32'h70,       32'h70,       2'b00);
    vecs[12] = mk(0, 0,  32'h0,        0, 0,  32'h0,        1, 12, 12, 9,  32'h0,        32'h22,       2'b00);
    vecs[13] = mk(1, 9,  32'h99,       0, 0,  32'h0,        0, 0,  12, 9,  32'h0,        32'h99,       2'b01);
    vecs[14] = mk(1, 31, 32'hA5A5A5A5, 0, 0,  32'h0,        0, 0,  31, 30, 32'hA5A5A5A5, 32'h0,        2'b00); // top reg
    vecs[15] = mk(0, 0,  32'h0,        0, 0,  32'h0,        0, 0,  31, 12, 32'hA5A5A5A5, 32'h0,        2'b10);

    idle_inputs();
    ra  = '0;
    rst = 1'b1;
    tick();
    tick();

    // Reset state while rst is held.
    check("reset_busy", {31'b0, busy}, 32'h1);
    check("reset_pend", {30'b0, pend}, 32'h0);
    check("reset_rd", rd[31:0] | rd[63:32], 32'h0);

    // First sweep after power-up.
    rst = 1'b0;
    count_sweep(n_edge);
    check("sweep1_edges", n_edge, 32'd32);

    // Fill every register with garbage and reserve one, then reset.
    for (int i = 1; i < 32; i++) begin
      we0 = 1'b1; wa0 = 5'(i); wd0 = 32'hC0DE0000 | i;
      tick();
    end
    idle_inputs();
    ra = {5'd17, 5'd3};
    #1;
    check("garbage_r3", rd[31:0], 32'hC0DE0003);
    res_valid = 1'b1; res_addr = 5'd17;
    tick();
    idle_inputs();
    #1;
    check("garbage_pend", {30'b0, pend}, 32'h2);

    // Reset sweep with writes and a reserve held throughout.
    do_reset();
    we0 = 1'b1; wa0 = 5'd3; wd0 = 32'hBAD00003;
    we1 = 1'b1; wa1 = 5'd4; wd1 = 32'hBAD00004;
    res_valid = 1'b1; res_addr = 5'd4;
    ra = {5'd4, 5'd3};
    #1;
    check("sweep_rd_busy", rd[31:0] | rd[63:32], 32'h0);
    check("sweep_pend_busy", {30'b0, pend}, 32'h0);
    count_sweep(n_edge);
    idle_inputs();
    check("sweep2_edges", n_edge, 32'd32);
    check("sweep2_busy", {31'b0, busy}, 32'h0);
    #1;
    check("sweep_pend_after", {30'b0, pend}, 32'h0);
    for (int i = 0; i < 32; i++) begin
      ra = {5'(31 - i), 5'(i)};
      #1;
      check($sformatf("clear_r%0d", i), rd[31:0], 32'h0);
      check($sformatf("clear_r%0d_p1", 31 - i), rd[63:32], 32'h0);
    end

    // Mid-sweep reset: rst at sweep cycle 10 restarts the full count.
    do_reset();
    for (int i = 0; i < 10; i++) tick();
    check("mid_busy_10", {31'b0, busy}, 32'h1);
    do_reset();
    count_sweep(n_edge);
    check("mid_sweep_edges", n_edge, 32'd32);

    // Table-driven vectors.
    for (int k = 0; k < 16; k++) begin
      we0 = vecs[k].we0; wa0 = vecs[k].wa0; wd0 = vecs[k].wd0;
      we1 = vecs[k].we1; wa1 = vecs[k].wa1; wd1 = vecs[k].wd1;
      res_valid = vecs[k].res_valid; res_addr = vecs[k].res_addr;
      ra = {vecs[k].ra1, vecs[k].ra0};
      #2;
      check($sformatf("v%0d_rd0", k), rd[31:0], vecs[k].exp_rd0);
      check($sformatf("v%0d_rd1", k), rd[63:32], vecs[k].exp_rd1);
      check($sformatf("v%0d_pend", k), {30'b0, pend}, {30'b0, vecs[k].exp_pend});
      tick();
    end
    idle_inputs();

    // A reset in RUN drops all reservations and blanks reads immediately.
    ra = {5'd12, 5'd31};
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("rerst_busy", {31'b0, busy}, 32'h1);
    check("rerst_pend", {30'b0, pend}, 32'h0);
    check("rerst_rd0", rd[31:0], 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the MIPS32 core, successor to the fixed 32x32 two-read/one-write file. It adds configurable width, depth and read-port count, a second write port for the late writeback path, write-to-read forwarding, a hardwired zero register, and a reset-time clearing sweep. It also adds a per-register pending scoreboard that the decode stage uses for hazard detection. It sits between decode (read ports, reserve) and writeback (write ports).

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
- NRD, 2, number of read ports
- ZERO_REG, 1, when 1 register 0 always reads 0 and is never written or reserved

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- ra  in  NRD*ADDR_W  read addresses, port i at bits [i*ADDR_W +: ADDR_W]
- rd  out  NRD*DATA_W  read data, combinational, port i at [i*DATA_W +: DATA_W]
- pend  out  NRD  read port i targets a register with an outstanding reservation
- we0, wa0, wd0  in  1/ADDR_W/DATA_W  write port 0 (main writeback)
- we1, wa1, wd1  in  1/ADDR_W/DATA_W  write port 1 (late writeback); wins on address collision
- res_valid  in  1  reserve res_addr as pending
- res_addr  in  ADDR_W  register being reserved
- busy  out  1  clearing sweep in progress; writes and reserves are ignored

## Operation
- FSM states are CLEAR and RUN.
  - rst=1: state←CLEAR, sweep counter ctr←0, every scoreboard bit←0.
  - In CLEAR with rst=0, each edge writes mem[ctr]←0 and increments ctr. When ctr==DEPTH-1, the FSM goes to RUN.
  - busy = (state==CLEAR).
- Writes act only in RUN.
  - we0 writes mem[wa0]←wd0 and we1 writes mem[wa1]←wd1 on the same edge.
  - If wa0==wa1 and both enables are high, wd1 is stored.
  - With ZERO_REG=1, writes to address 0 are dropped.
- Reads are combinational for each port i, with this priority:
  1. busy → 0
  2. ZERO_REG and ra_i==0 → 0
  3. we1 && wa1==ra_i → wd1
  4. we0 && wa0==ra_i → wd0
  5. otherwise mem[ra_i]
- Scoreboard has one bit per register and is active in RUN only.
  - res_valid sets sb[res_addr] on the next edge.
  - A write through either port clears sb[wa].
  - If a reserve and a write hit the same address on the same edge, the reserve wins and the bit stays set, because the reserve belongs to a newer producer.
  - Reserves to register 0 are ignored when ZERO_REG=1.
  - pend[i] = sb[ra_i] && !(write to ra_i this cycle && !(res_valid && res_addr==ra_i)).
- Addresses are unsigned with no range checks, since DEPTH == 2**ADDR_W.

## Timing
- Reset values: busy=1, pend=0, rd=0 on all ports.
- Clear latency: busy deasserts after exactly DEPTH rising edges with rst=0 following reset. rst asserted mid-sweep restarts the sweep at ctr=0.
- Write latency: data is visible in mem on the edge after we is sampled, and visible on rd in the same cycle via forwarding.
- Reserve latency: pend rises the cycle after res_valid.
- Inputs sampled during busy have no architectural effect.

## Structure
- Package regfile_pkg holds:
  - state enum {CLEAR, RUN}
  - localparam helper functions for port slicing
- Sub-module regfile_scoreboard (DEPTH bits) owns:
  - set, clear and priority logic
  - pend lookup for NRD ports
- The top level holds the memory array, sweep FSM, write arbitration and forwarding muxes.

## Test plan
- Reset sweep: preload garbage via backdoor, pulse rst for 1 cycle. Require busy=1 for 32 edges then 0, and every register reads 0. Writes issued during busy are lost.
- Forwarding: we0=1, wa0=5, wd0=0xDEADBEEF, ra[0]=5. Require rd port 0 = 0xDEADBEEF in the same cycle and mem[5]=0xDEADBEEF afterwards.
- Dual-write collision: we0=we1=1, wa0=wa1=9, wd0=0x11, wd1=0x22. Require the same-cycle read and later reads of r9 to return 0x22.
- Zero register: write 0xFFFFFFFF to r0 and reserve r0. Require r0 reads 0 and pend=0.
- Scoreboard: reserve r7, then pend=1 on a read of r7 next cycle. Write r7 plus reserve r7 on the same edge: pend stays 1. A write to r7 alone clears pend the following cycle.
- Mid-sweep reset: assert rst at sweep cycle 10. Require busy stays high for a further 32 edges after rst deasserts.
